// File: rtl/adf4360_pkg.sv
// adf4360_pkg: shared state encoding, latch selects and defaults for the ADF4360 sequencer
package adf4360_pkg;
  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_TRIG, S_WAIT_START, S_WAIT_END, S_SETTLE, S_WAIT_LOCK, S_FINISH
  } state_t;
  localparam logic [1:0] SEL_R = 2'd0;
  localparam logic [1:0] SEL_C = 2'd1;
  localparam logic [1:0] SEL_N = 2'd2;
  localparam int NUM_PROF = 4;
  localparam int DEF_SETTLE_CYC = 1000;
  localparam int DEF_LOCK_TIMEOUT = 100000;
  function automatic int max3(input int a, input int b, input int c);
    return (a > b) ? ((a > c) ? a : c) : ((b > c) ? b : c);
  endfunction
endpackage

// File: rtl/adf4360_lock_filter.sv
// adf4360_lock_filter: synchronizes lock-detect and debounces it into a level with rise/fall strobes
module adf4360_lock_filter #(
  parameter int LOCK_STABLE = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic ld_i,
  output logic lvl_o,
  output logic rise_o,
  output logic fall_o
);
  localparam int W = $clog2(LOCK_STABLE + 1);
  logic s1, s2, flip;
  logic [W-1:0] cnt;
  assign flip = (s2 != lvl_o) && (cnt == W'(LOCK_STABLE - 1));
  assign rise_o = flip & s2;
  assign fall_o = flip & ~s2;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      cnt <= '0;
      lvl_o <= 1'b0;
    end else begin
      s1 <= ld_i;
      s2 <= s1;
      cnt <= (s2 == lvl_o || flip) ? '0 : cnt + W'(1);
      if (flip) lvl_o <= s2;
    end
endmodule

// File: rtl/adf4360_ctrl.sv
// adf4360_ctrl: profile table and program/trigger/lock-qualify sequencer for the ADF4360 programmer
module adf4360_ctrl
  import adf4360_pkg::*;
#(
  parameter int SETTLE_CYC = DEF_SETTLE_CYC,
  parameter int LOCK_STABLE = 16,
  parameter int LOCK_TIMEOUT = DEF_LOCK_TIMEOUT,
  parameter int START_GUARD = 15
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        wr_i,
  input  logic [1:0]  wr_prof_i,
  input  logic [1:0]  wr_sel_i,
  input  logic [23:0] wr_data_i,
  input  logic        req_i,
  input  logic [1:0]  req_prof_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        locked_o,
  output logic        timeout_o,
  output logic        err_o,
  output logic        lost_o,
  output logic [1:0]  cur_prof_o,
  output logic        pll_trig_o,
  input  logic        pll_ready_i,
  output logic [23:0] pll_R_o,
  output logic [23:0] pll_C_o,
  output logic [23:0] pll_N_o,
  input  logic        ld_i
);
  localparam int CMAX = max3(SETTLE_CYC, LOCK_TIMEOUT, START_GUARD);
  localparam int CW = $clog2(CMAX + 1);
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [23:0] tab [NUM_PROF][3];
  logic pend, accept, lvl, rise, fall, lvl_nx;
  logic [1:0] pend_prof, prof;
  adf4360_lock_filter #(.LOCK_STABLE(LOCK_STABLE)) u_filt (
    .clk_i(clk_i), .rst_i(rst_i), .ld_i(ld_i), .lvl_o(lvl), .rise_o(rise), .fall_o(fall)
  );
  assign lvl_nx = (lvl | rise) & ~fall;
  assign accept = (state == S_IDLE) && (req_i || pend) && pll_ready_i;
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:       state_n = accept ? S_LOAD : S_IDLE;
      S_LOAD:       state_n = S_TRIG;
      S_TRIG:       state_n = S_WAIT_START;
      S_WAIT_START: state_n = !pll_ready_i ? S_WAIT_END : (cnt == CW'(START_GUARD - 1)) ? S_FINISH : S_WAIT_START;
      S_WAIT_END:   state_n = pll_ready_i ? S_SETTLE : S_WAIT_END;
      S_SETTLE:     state_n = (cnt == CW'(SETTLE_CYC - 1)) ? S_WAIT_LOCK : S_SETTLE;
      S_WAIT_LOCK:  state_n = (lvl_nx || cnt == CW'(LOCK_TIMEOUT - 1)) ? S_FINISH : S_WAIT_LOCK;
      default:      state_n = S_IDLE;
    endcase
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state <= S_IDLE;
      cnt <= '0;
      pend <= 1'b0;
      pend_prof <= '0;
      prof <= '0;
      for (int p = 0; p < NUM_PROF; p++)
        for (int s = 0; s < 3; s++)
          tab[p][s] <= '0;
      busy_o <= 1'b0;
      done_o <= 1'b0;
      locked_o <= 1'b0;
      timeout_o <= 1'b0;
      err_o <= 1'b0;
      lost_o <= 1'b0;
      cur_prof_o <= '0;
      pll_trig_o <= 1'b0;
      pll_R_o <= '0;
      pll_C_o <= '0;
      pll_N_o <= '0;
    end else begin
      state <= state_n;
      cnt <= (state_n != state) ? '0 : (cnt == CW'(CMAX)) ? cnt : cnt + CW'(1);
      if (wr_i && wr_sel_i <= SEL_N) tab[wr_prof_i][wr_sel_i] <= wr_data_i;
      if (accept) begin
        prof <= req_i ? req_prof_i : pend_prof;
        pend <= 1'b0;
        locked_o <= 1'b0;
        timeout_o <= 1'b0;
        err_o <= 1'b0;
      end else if (req_i) begin
        pend <= 1'b1;
        pend_prof <= req_prof_i;
      end
      if (state == S_LOAD) begin
        pll_R_o <= tab[prof][SEL_R];
        pll_C_o <= tab[prof][SEL_C];
        pll_N_o <= tab[prof][SEL_N];
      end
      if (state != S_FINISH && state_n == S_FINISH) cur_prof_o <= prof;
      if (state == S_WAIT_START && state_n == S_FINISH) err_o <= 1'b1;
      if (state == S_WAIT_LOCK && state_n == S_FINISH) begin
        locked_o <= lvl_nx;
        timeout_o <= ~lvl_nx;
      end
      lost_o <= (state == S_IDLE) && locked_o && !lvl_nx;
      if (state == S_IDLE && locked_o && !lvl_nx) locked_o <= 1'b0;
      pll_trig_o <= state == S_TRIG;
      busy_o <= state != S_IDLE && state != S_FINISH;
      done_o <= state == S_FINISH;
    end
endmodule

// File: tb/tb_adf4360_ctrl.sv
// tb_adf4360_ctrl: scoreboard bench for the ADF4360 sequencer with a behavioural programmer stub
module tb_adf4360_ctrl;
  import adf4360_pkg::*;
  localparam int SETTLE = 20, STABLE = 16, TMO = 200, GUARD = 15;
  logic clk = 1'b0, rst = 1'b1, wr = 1'b0, req = 1'b0, ld = 1'b0, ready = 1'b1, dead = 1'b0;
  logic [1:0] wr_prof = '0, wr_sel = '0, req_prof = '0, cur_prof;
  logic [23:0] wr_data = '0, pr, pc, pn;
  logic busy, done, locked, timeout, err, lost, trig;
  int n_chk = 0, n_bad = 0, n_done = 0, n_trig = 0, n_lost = 0, n_wl = 0, n_ws = 0, sh = 0;
  typedef struct {logic [1:0] prof; logic [23:0] r, c, n; logic lk, to, er;} exp_t;
  exp_t q[$];
  exp_t e;
  logic [23:0] tab [4][3];
  always #5 clk = ~clk;
  adf4360_ctrl #(.SETTLE_CYC(SETTLE), .LOCK_STABLE(STABLE), .LOCK_TIMEOUT(TMO), .START_GUARD(GUARD)) dut (
    .clk_i(clk), .rst_i(rst), .wr_i(wr), .wr_prof_i(wr_prof), .wr_sel_i(wr_sel), .wr_data_i(wr_data),
    .req_i(req), .req_prof_i(req_prof), .busy_o(busy), .done_o(done), .locked_o(locked),
    .timeout_o(timeout), .err_o(err), .lost_o(lost), .cur_prof_o(cur_prof), .pll_trig_o(trig),
    .pll_ready_i(ready), .pll_R_o(pr), .pll_C_o(pc), .pll_N_o(pn), .ld_i(ld)
  );
  always @(posedge clk)
    if (trig && !dead) begin
      ready <= 1'b0;
      sh <= 80;
    end else if (sh > 0) begin
      sh <= sh - 1;
      if (sh == 1) ready <= 1'b1;
    end
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (trig) n_trig++;
    if (lost) n_lost++;
    if (dut.state == S_WAIT_LOCK) n_wl++;
    if (dut.state == S_WAIT_START) n_ws++;
    if (done) begin
      n_done++;
      check("busy_at_done", busy, 0);
      if (q.size() == 0) check("done_unexpected", 1, 0);
      else begin
        e = q.pop_front();
        check("cur_prof", cur_prof, e.prof);
        check("pll_r", pr, e.r);
        check("pll_c", pc, e.c);
        check("pll_n", pn, e.n);
        check("locked", locked, e.lk);
        check("timeout", timeout, e.to);
        check("err", err, e.er);
      end
    end
  end
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic write(input logic [1:0] p, input logic [1:0] s, input logic [23:0] d);
    wr = 1'b1; wr_prof = p; wr_sel = s; wr_data = d;
    tick();
    wr = 1'b0;
    if (s != 2'd3) tab[p][s] = d;
  endtask
  task automatic push(input logic [1:0] p, input logic lk, input logic to, input logic er);
    q.push_back('{p, tab[p][0], tab[p][1], tab[p][2], lk, to, er});
  endtask
  task automatic request(input logic [1:0] p);
    req = 1'b1; req_prof = p;
    tick();
    req = 1'b0;
  endtask
  task automatic wait_done(input int target, input int budget);
    int k = 0;
    while (n_done < target && k < budget) begin tick(); k++; end
    check("done_wait", n_done >= target, 1);
  endtask
  task automatic wait_state(input state_t s, input int budget);
    int k = 0;
    while (dut.state != s && k < budget) begin tick(); k++; end
    check("state_wait", dut.state == s, 1);
  endtask
  task automatic clear_model();
    for (int p = 0; p < 4; p++)
      for (int s = 0; s < 3; s++)
        tab[p][s] = '0;
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    clear_model();
    tick(2);
    check("rst_flags", {busy, done, locked, timeout, err, lost, trig, cur_prof}, 0);
    check("rst_r", pr, 0);
    check("rst_c", pc, 0);
    check("rst_n", pn, 0);
    rst = 1'b0;
    tick();
    write(1, SEL_R, 24'h123456);
    write(1, SEL_C, 24'h234567);
    write(1, SEL_N, 24'h345678);
    write(1, 2'd3, 24'hFFFFFF);
    ld = 1'b1;
    push(1, 1, 0, 0);
    request(1);
    tick();
    check("busy_c2", busy, 1);
    check("r_c2", pr, 24'h123456);
    check("c_c2", pc, 24'h234567);
    check("n_c2", pn, 24'h345678);
    check("trig_c2", trig, 0);
    tick();
    check("trig_c3", trig, 1);
    tick();
    check("trig_c4", trig, 0);
    wait_done(1, 1000);
    check("trig_count", n_trig, 1);
    tick(2);
    check("locked_idle", locked, 1);
    ld = 1'b0; tick(10); ld = 1'b1; tick(40);
    check("no_lost_glitch", n_lost, 0);
    check("still_locked", locked, 1);
    ld = 1'b0; tick(40);
    check("lost_once", n_lost, 1);
    check("lost_unlock", locked, 0);
    n_wl = 0;
    push(1, 0, 1, 0);
    request(1);
    wait_state(S_WAIT_LOCK, 1000);
    ld = 1'b1; tick(10); ld = 1'b0;
    wait_done(2, 1000);
    check("wait_lock_cycles", n_wl, TMO);
    write(2, SEL_R, 24'h0A0B0C);
    write(2, SEL_N, 24'h111111);
    write(3, SEL_R, 24'h333333);
    write(3, SEL_C, 24'h444444);
    write(3, SEL_N, 24'h555555);
    ld = 1'b1; tick(20);
    push(1, 1, 0, 0);
    request(1);
    tick(5);
    request(2);
    tick(5);
    request(3);
    push(3, 1, 0, 0);
    wait_done(4, 2000);
    tick(300);
    check("extra_seq", n_done, 4);
    check("cur_prof_3", cur_prof, 3);
    push(2, 1, 0, 0);
    request(2);
    wait_state(S_WAIT_END, 100);
    write(2, SEL_N, 24'hABCDEF);
    wait_done(5, 1000);
    wr = 1'b1; wr_prof = 2; wr_sel = SEL_C; wr_data = 24'h5A5A5A;
    req = 1'b1; req_prof = 2;
    tab[2][1] = 24'h5A5A5A;
    push(2, 1, 0, 0);
    tick();
    wr = 1'b0; req = 1'b0;
    tick();
    check("same_cycle_c", pc, 24'h5A5A5A);
    check("new_n_loaded", pn, 24'hABCDEF);
    wait_done(6, 1000);
    dead = 1'b1;
    n_ws = 0;
    push(0, 0, 0, 1);
    request(0);
    wait_done(7, 500);
    check("wait_start_cycles", n_ws, GUARD);
    dead = 1'b0;
    tick(5);
    request(1);
    wait_state(S_SETTLE, 500);
    rst = 1'b1;
    #1;
    check("rst_mid_flags", {busy, done, locked, timeout, err, lost, trig, cur_prof}, 0);
    check("rst_mid_r", pr, 0);
    check("rst_mid_n", pn, 0);
    tick();
    rst = 1'b0;
    clear_model();
    tick();
    write(1, SEL_R, 24'h765432);
    write(1, SEL_C, 24'h0F0F0F);
    write(1, SEL_N, 24'h00C0DE);
    push(1, 1, 0, 0);
    request(1);
    wait_done(8, 1000);
    tick(5);
    check("queue_empty", q.size(), 0);
    check("lost_total", n_lost, 1);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
